arm1_prog_loader: RTL and testbench

//  Boot-time program loader for the ARM1 8-bit multicycle core: accepts a byte

---
 rtl/arm1_pkg.sv | 30 +++
 rtl/arm1_prog_loader.sv | 121 ++++++++++++
 tb/tb_arm1_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm1_pkg.sv
// ---------------------------------------------------------------------------
// arm1_pkg
// Shared definitions for the ARM1 8-bit multicycle core and its boot loader.
// It holds the memory geometry, the program-loader state encoding and a
// mod-256 checksum helper.
// ---------------------------------------------------------------------------
package arm1_pkg;

    localparam int ARM1_ADDR_W    = 4;
    localparam int ARM1_DATA_W    = 8;
    localparam int ARM1_MEM_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    // Modular byte sum. Carries out of the top bit are discarded on purpose.
    function automatic logic [ARM1_DATA_W-1:0] csum_add(
        input logic [ARM1_DATA_W-1:0] acc,
        input logic [ARM1_DATA_W-1:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/arm1_prog_loader.sv
// ---------------------------------------------------------------------------
// arm1_prog_loader
// Boot-time program loader. It receives a frame (LEN, LEN image bytes, CSUM)
// over a valid/ready stream and writes the image bytes into the unified
// memory starting at address 0. The core is held in reset until an image
// with a valid length and a zero mod-256 sum (image + CSUM) has been loaded.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous active-high reset
//   start          : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   in_valid       : stream byte valid
//   in_data        : stream byte
//   in_ready       : loader accepts a byte (LEN/DATA/CSUM states)
//   mem_write      : registered memory write strobe
//   mem_address    : registered memory write address
//   mem_write_data : registered memory write data
//   cpu_reset      : holds the core in reset (low only in DONE)
//   done           : image loaded and checksum good
//   error          : bad length or bad checksum
//   checksum       : running mod-256 sum of image bytes and CSUM byte
// ---------------------------------------------------------------------------
module arm1_prog_loader
    import arm1_pkg::*;
#(
    parameter int ADDR_W    = ARM1_ADDR_W,
    parameter int DATA_W    = ARM1_DATA_W,
    parameter int MEM_DEPTH = ARM1_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    loader_state_t     state;
    // One bit wider than the address so that a length of MEM_DEPTH fits and
    // the byte index can be compared with it without wrapping.
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_next;
    logic [DATA_W-1:0] csum_next;
    logic              xfer;

    function automatic logic len_is_valid(input logic [DATA_W-1:0] len);
        return (len != '0) && (len <= DATA_W'(MEM_DEPTH));
    endfunction

    assign in_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cpu_reset = (state != DONE);

    assign xfer      = in_valid && in_ready;
    assign idx_next  = idx + (ADDR_W+1)'(1);
    assign csum_next = csum_add(checksum, in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            idx            <= '0;
            checksum       <= '0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            // The write strobe is a single-cycle pulse per accepted image byte.
            mem_write <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        checksum <= '0;
                        count    <= '0;
                        idx      <= '0;
                        state    <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        if (len_is_valid(in_data)) begin
                            count <= in_data[ADDR_W:0];
                            state <= DATA;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem_write      <= 1'b1;
                        mem_address    <= idx[ADDR_W-1:0];
                        mem_write_data <= in_data;
                        checksum       <= csum_next;
                        idx            <= idx_next;
                        if (idx_next == count) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        checksum <= csum_next;
                        state    <= (csum_next == '0) ? DONE : ERR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm1_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_arm1_prog_loader
// Self-checking bench for arm1_prog_loader. A frame-level model tracks how
// many bytes of the current frame have been accepted and derives every
// output from that; it is compared against the DUT on each falling edge.
// Directed frames with literal expectations are followed by random frames.
// ---------------------------------------------------------------------------
module tb_arm1_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_write;
    logic [3:0] mem_address;
    logic [7:0] mem_write_data;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arm1_prog_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .cpu_reset      (cpu_reset),
        .done           (done),
        .error          (error),
        .checksum       (checksum)
    );

    // ---------------- frame-level reference model ----------------
    bit         m_loading;   // a frame is in progress (bytes are accepted)
    int         m_n;         // bytes accepted in the current frame
    int         m_len;       // declared image length
    logic [7:0] m_sum;       // mod-256 sum of image + CSUM bytes
    int         m_status;    // 0 none, 1 good image, 2 error
    bit         m_wr;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loading = 0; m_n = 0; m_len = 0; m_sum = 8'h00; m_status = 0;
            m_wr = 0; m_addr = 4'h0; m_wdata = 8'h00;
        end else begin
            m_wr = 0;
            if (!m_loading) begin
                if (start) begin
                    m_loading = 1; m_n = 0; m_sum = 8'h00; m_status = 0;
                end
            end else if (in_valid) begin
                if (m_n == 0) begin
                    m_len = int'(in_data);
                    if (m_len < 1 || m_len > 16) begin
                        m_loading = 0; m_status = 2;
                    end
                end else if (m_n <= m_len) begin
                    m_wr = 1; m_addr = 4'(m_n - 1); m_wdata = in_data;
                    m_sum = m_sum + in_data;
                end else begin
                    m_sum = m_sum + in_data;
                    m_loading = 0;
                    m_status = (m_sum == 8'h00) ? 1 : 2;
                end
                m_n++;
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Written memory as seen on the DUT write port, plus a running write count.
    logic [7:0] shadow [16];
    int         wr_cnt = 0;

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),       32'(m_loading));
        chk("mem_write", 32'(mem_write),      32'(m_wr));
        chk("mem_addr",  32'(mem_address),    32'(m_addr));
        chk("mem_data",  32'(mem_write_data), 32'(m_wdata));
        chk("cpu_reset", 32'(cpu_reset),      32'(m_status != 1));
        chk("done",      32'(done),           32'(m_status == 1));
        chk("error",     32'(error),          32'(m_status == 2));
        chk("checksum",  32'(checksum),       32'(m_sum));
        if (mem_write === 1'b1) begin
            wr_cnt++;
            shadow[mem_address] = mem_write_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Idle for gap cycles (optionally pulsing start during the gap), then
    // present one byte and hold it until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit start_in_gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            start = start_in_gap && (g == 0);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (in_ready) ok = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: byte %0h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_frame2();
        pulse_start();
        send_byte(8'h03, 0, 0);
        send_byte(8'hC5, 0, 0);
        send_byte(8'h0A, 0, 0);
        send_byte(8'h21, 0, 0);
        send_byte(8'h10, 0, 0);
        tick(); tick();
    endtask

    int w0;

    initial begin
        #1 reset = 1'b1;
        tick(); tick();
        // Test 1: reset state
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t1_in_ready",  32'(in_ready),  32'd0);
        chk("t1_mem_write", 32'(mem_write), 32'd0);
        chk("t1_done",      32'(done),      32'd0);
        chk("t1_error",     32'(error),     32'd0);
        chk("t1_checksum",  32'(checksum),  32'h00);
        reset = 1'b0;
        // Bytes offered while idle are not taken.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) tick();
        in_valid = 1'b0;

        // Test 2: good 3-byte image
        w0 = wr_cnt;
        send_frame2();
        chk("t2_writes",    32'(wr_cnt - w0), 32'd3);
        chk("t2_mem0",      32'(shadow[0]),   32'hC5);
        chk("t2_mem1",      32'(shadow[1]),   32'h0A);
        chk("t2_mem2",      32'(shadow[2]),   32'h21);
        chk("t2_done",      32'(done),        32'd1);
        chk("t2_cpu_reset", 32'(cpu_reset),   32'd0);
        chk("t2_checksum",  32'(checksum),    32'h00);

        // Test 3: bad checksum
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h03, 0, 0); send_byte(8'hC5, 0, 0); send_byte(8'h0A, 0, 0);
        send_byte(8'h21, 0, 0); send_byte(8'h11, 0, 0);
        tick(); tick();
        chk("t3_writes",    32'(wr_cnt - w0), 32'd3);
        chk("t3_error",     32'(error),       32'd1);
        chk("t3_cpu_reset", 32'(cpu_reset),   32'd1);
        chk("t3_done",      32'(done),        32'd0);
        chk("t3_checksum",  32'(checksum),    32'h01);

        // Test 4: zero and oversize lengths
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0, 0);
        tick();
        chk("t4_err_len0", 32'(error), 32'd1);
        pulse_start();
        send_byte(8'h11, 0, 0);
        tick();
        chk("t4_err_len17", 32'(error), 32'd1);
        chk("t4_writes", 32'(wr_cnt - w0), 32'd0);

        // Test 5: full 16-byte image with alternating gaps
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h10, 0, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 0);
        send_byte(8'h88, 1, 0);
        tick(); tick();
        chk("t5_writes", 32'(wr_cnt - w0), 32'd16);
        for (int i = 0; i < 16; i++) chk("t5_mem", 32'(shadow[i]), 32'(i));
        chk("t5_done", 32'(done), 32'd1);

        // Test 6: reset in the middle of the image
        pulse_start();
        send_byte(8'h03, 0, 0); send_byte(8'hC5, 0, 0); send_byte(8'h0A, 0, 0);
        reset = 1'b1;
        #1;
        chk("t6_mem_write", 32'(mem_write), 32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t6_in_ready",  32'(in_ready),  32'd0);
        tick();
        reset = 1'b0;
        tick();
        send_frame2();
        chk("t6_done", 32'(done), 32'd1);

        // Random frames: lengths incl. illegal ones, good/bad checksums,
        // random gaps, and stray start pulses during a load.
        for (int f = 0; f < 25; f++) begin
            int         len, r, expw;
            logic [7:0] sum, cs;
            bit         good_len;
            r = int'($urandom_range(0, 9));
            if (r == 0)      len = 0;
            else if (r == 1) len = int'($urandom_range(17, 255));
            else             len = int'($urandom_range(1, 16));
            good_len = (len >= 1 && len <= 16);
            w0 = wr_cnt;
            pulse_start();
            send_byte(8'(len), int'($urandom_range(0, 2)), 0);
            sum = 8'h00;
            if (good_len) begin
                for (int i = 0; i < len; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    sum = sum + b;
                    send_byte(b, int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
                end
                cs = ($urandom_range(0, 3) != 0) ? 8'(8'h00 - sum) : 8'($urandom);
                send_byte(cs, int'($urandom_range(0, 2)), 0);
            end else begin
                cs = 8'h00;
            end
            tick(); tick();
            expw = good_len ? len : 0;
            chk("rnd_writes", 32'(wr_cnt - w0), 32'(expw));
            chk("rnd_done", 32'(done), 32'(good_len && (8'(sum + cs) == 8'h00)));
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
